// File: rtl/mips_debug_ctrl_if.sv
// mips_debug_ctrl_if: GPIO command/step link and core-side debug/imem signals of the run controller.
interface mips_debug_ctrl_if #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_DBG  = 8
);
    logic               i_continue;
    logic               i_valid;
    logic               i_SCLK;
    logic [3:0]         i_SPI_cs;
    logic [NB_BITS-1:0] i_MOSI;
    logic               i_halt;
    logic [NB_BITS-1:0] i_dbg_data;
    logic [NB_BITS-1:0] o_MISO;
    logic               o_mips_en;
    logic               o_imem_we;
    logic [NB_ADDR-1:0] o_imem_addr;
    logic [NB_BITS-1:0] o_imem_data;
    logic [NB_DBG-1:0]  o_dbg_addr;
    logic [1:0]         o_state;

    modport slave (
        input  i_continue, i_valid, i_SCLK, i_SPI_cs, i_MOSI, i_halt, i_dbg_data,
        output o_MISO, o_mips_en, o_imem_we, o_imem_addr, o_imem_data, o_dbg_addr, o_state
    );
    modport master (
        output i_continue, i_valid, i_SCLK, i_SPI_cs, i_MOSI, i_halt, i_dbg_data,
        input  o_MISO, o_mips_en, o_imem_we, o_imem_addr, o_imem_data, o_dbg_addr, o_state
    );
endinterface

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: decodes GPIO serial commands to load imem / select readback,
// and sequences the MIPS core through halted, single-step, free-run and done.
module mips_debug_ctrl #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_DBG  = 8
) (
    input logic i_clk,
    input logic i_rst,
    mips_debug_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP, RUN, DONE} state_t;
    localparam logic [1:0] SRC_DBG = 2'd0, SRC_CNT = 2'd1, SRC_STAT = 2'd2;

    state_t             state_q, state_d;
    logic [1:0]         cont_q;
    logic [2:0]         valid_q, sclk_q;
    logic [1:0][3:0]    cs_q;
    logic [1:0][15:0]   mosi_q;
    logic [15:0]        lo_q;
    logic [NB_BITS-1:0] data_q, cnt_q, dbg_q, miso_q, miso_d;
    logic               we_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DBG-1:0]  dbg_addr_q;
    logic [1:0]         src_q;
    logic               cont, v_edge, mips_en, mem_ok;
    logic [3:0]         cmd;

    assign cont    = cont_q[1];
    assign v_edge  = valid_q[1] & ~valid_q[2];
    assign cmd     = (sclk_q[1] & ~sclk_q[2]) ? cs_q[1] : 4'h0;
    assign mips_en = (state_q == STEP) || (state_q == RUN);
    // Memory-loading commands must not race a running core's fetches.
    assign mem_ok  = (state_q == IDLE) || (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cont ? RUN : (v_edge ? STEP : IDLE);
            STEP:    state_d = bus.i_halt ? DONE : IDLE;
            RUN:     state_d = bus.i_halt ? DONE : (cont ? RUN : IDLE);
            default: state_d = DONE;
        endcase
    end

    always_comb begin
        miso_d = src_q == SRC_CNT  ? cnt_q :
                 src_q == SRC_STAT ? {{(NB_BITS-2-NB_ADDR){1'b0}}, state_q, addr_q} : dbg_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cont_q     <= '0;
            valid_q    <= '0;
            sclk_q     <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            lo_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            dbg_q      <= '0;
            miso_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dbg_addr_q <= '0;
            src_q      <= SRC_DBG;
        end else begin
            state_q <= state_d;
            cont_q  <= {cont_q[0], bus.i_continue};
            valid_q <= {valid_q[1:0], bus.i_valid};
            sclk_q  <= {sclk_q[1:0], bus.i_SCLK};
            cs_q    <= {cs_q[0], bus.i_SPI_cs};
            mosi_q  <= {mosi_q[0], bus.i_MOSI[15:0]};
            cnt_q   <= (mips_en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
            we_q    <= mem_ok && cmd == 4'h2;
            dbg_q   <= bus.i_dbg_data;
            miso_q  <= miso_d;
            if (mem_ok && cmd == 4'h1) lo_q <= mosi_q[1];
            if (mem_ok && cmd == 4'h2) data_q <= {mosi_q[1], lo_q};
            if (we_q) addr_q <= addr_q + 1'b1;
            else if (mem_ok && cmd == 4'h3) addr_q <= mosi_q[1][NB_ADDR-1:0];
            if (cmd == 4'h4) begin
                dbg_addr_q <= mosi_q[1][NB_DBG-1:0];
                src_q      <= SRC_DBG;
            end else if (cmd == 4'h5) src_q <= SRC_CNT;
            else if (cmd == 4'h6) src_q <= SRC_STAT;
        end
    end

    assign bus.o_MISO      = miso_q;
    assign bus.o_mips_en   = mips_en;
    assign bus.o_imem_we   = we_q;
    assign bus.o_imem_addr = addr_q;
    assign bus.o_imem_data = data_q;
    assign bus.o_dbg_addr  = dbg_addr_q;
    assign bus.o_state     = state_q;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: imem writes are scoreboarded against a bench model; core enable
// pulses are counted by a monitor and compared with the sequencing the stimulus implies.
module tb_mips_debug_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_debug_ctrl_if #(.NB_BITS(32), .NB_ADDR(10), .NB_DBG(8)) bus ();
    mips_debug_ctrl #(.NB_BITS(32), .NB_ADDR(10), .NB_DBG(8)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    wr_t         wr_exp;
    int          n_chk, n_fail;
    int          en_cycles, en_pulses, run_len, max_run;
    logic        en_prev;
    logic [9:0]  addr_m;
    logic [15:0] lo_m;
    bit          running;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_imem_we) begin
                if (wr_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
                else begin
                    wr_exp = wr_q.pop_front();
                    check("we_addr", {22'd0, bus.o_imem_addr}, {22'd0, wr_exp.addr});
                    check("we_data", bus.o_imem_data, wr_exp.data);
                end
            end
            if (bus.o_mips_en) begin
                en_cycles++;
                run_len++;
                if (!en_prev) en_pulses++;
                if (run_len > max_run) max_run = run_len;
            end else run_len = 0;
            en_prev = bus.o_mips_en;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [3:0] cs, input logic [31:0] mosi);
        @(negedge clk);
        bus.i_SPI_cs = cs;
        bus.i_MOSI   = mosi;
        bus.i_SCLK   = 1'b1;
        if (!running) begin
            if (cs == 4'h1) lo_m = mosi[15:0];
            if (cs == 4'h2) begin
                wr_q.push_back('{addr_m, {mosi[15:0], lo_m}});
                addr_m = addr_m + 10'd1;
            end
            if (cs == 4'h3) addr_m = mosi[9:0];
        end
        cyc(4);
        bus.i_SCLK = 1'b0;
        cyc(3);
    endtask

    task automatic clr_mon();
        en_cycles = 0;
        en_pulses = 0;
        max_run   = 0;
    endtask

    initial begin
        bus.i_continue = 0; bus.i_valid = 0; bus.i_SCLK = 0; bus.i_SPI_cs = 0;
        bus.i_MOSI = 0; bus.i_halt = 0; bus.i_dbg_data = 0;
        n_chk = 0; n_fail = 0; en_prev = 0; run_len = 0; running = 0;
        addr_m = 0; lo_m = 0;
        clr_mon();
        cyc(3);
        check("rst_state", {30'd0, bus.o_state}, 32'd0);
        check("rst_en", {31'd0, bus.o_mips_en}, 32'd0);
        check("rst_we", {31'd0, bus.o_imem_we}, 32'd0);
        check("rst_addr", {22'd0, bus.o_imem_addr}, 32'd0);
        check("rst_data", bus.o_imem_data, 32'd0);
        check("rst_dsel", {24'd0, bus.o_dbg_addr}, 32'd0);
        check("rst_miso", bus.o_MISO, 32'd0);
        rst = 1'b0;
        cyc(2);

        send(4'h3, 32'h010);
        send(4'h1, 32'h5678);
        send(4'h2, 32'h1234);
        check("addr_after_wr", {22'd0, bus.o_imem_addr}, 32'h011);
        check("data_after_wr", bus.o_imem_data, 32'h12345678);
        send(4'h3, 32'h3FF);
        send(4'h1, 32'hABCD);
        send(4'h2, 32'h9876);
        check("addr_wrap", {22'd0, bus.o_imem_addr}, 32'h000);
        check("wq_drained1", wr_q.size(), 32'd0);

        clr_mon();
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; cyc(3);
            bus.i_valid = 1'b0; cyc(3);
        end
        check("step_pulses", en_pulses, 32'd3);
        check("step_cycles", en_cycles, 32'd3);
        check("step_width", max_run, 32'd1);
        send(4'h5, 32'h0);
        check("rcnt_steps", bus.o_MISO, 32'd3);

        clr_mon();
        bus.i_continue = 1'b1; cyc(20);
        bus.i_continue = 1'b0; cyc(6);
        check("run_pulses", en_pulses, 32'd1);
        check("run_cycles", en_cycles, 32'd20);
        check("run_contig", max_run, 32'd20);
        check("run_back_idle", {30'd0, bus.o_state}, 32'd0);
        send(4'h5, 32'h0);
        check("rcnt_run", bus.o_MISO, 32'd23);

        running = 1;
        bus.i_continue = 1'b1; cyc(4);
        check("in_run", {30'd0, bus.o_state}, 32'd2);
        send(4'h1, 32'hFFFF);
        send(4'h2, 32'hEEEE);
        send(4'h3, 32'h123);
        check("run_addr_kept", {22'd0, bus.o_imem_addr}, 32'h000);
        bus.i_dbg_data = 32'hCAFE0001;
        send(4'h4, 32'h05);
        check("dsel_addr", {24'd0, bus.o_dbg_addr}, 32'h05);
        check("dsel_miso", bus.o_MISO, 32'hCAFE0001);
        bus.i_dbg_data = 32'h11112222;
        cyc(1);
        check("dbg_lat1", bus.o_MISO, 32'hCAFE0001);
        cyc(1);
        check("dbg_lat2", bus.o_MISO, 32'h11112222);

        bus.i_halt = 1'b1; cyc(1);
        bus.i_halt = 1'b0;
        check("halt_done", {30'd0, bus.o_state}, 32'd3);
        check("halt_en_off", {31'd0, bus.o_mips_en}, 32'd0);
        running = 0;
        clr_mon();
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1; cyc(3);
            bus.i_valid = 1'b0; cyc(3);
        end
        bus.i_continue = 1'b0; cyc(4);
        bus.i_continue = 1'b1; cyc(4);
        bus.i_continue = 1'b0; cyc(4);
        check("done_no_en", en_cycles, 32'd0);
        check("done_stays", {30'd0, bus.o_state}, 32'd3);

        send(4'h3, 32'h055);
        send(4'h2, 32'h4321);
        send(4'h6, 32'h0);
        cyc(1);
        check("rstat", bus.o_MISO, 32'h00000C56);
        check("wq_drained2", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
